// File: rtl/test_pattern_pkg.sv
// Shared types and colour constants for the video test-pattern source.
package test_pattern_pkg;

  typedef enum logic [2:0] {
    QUAD  = 3'd0,
    BARS  = 3'd1,
    CHECK = 3'd2,
    RAMP  = 3'd3,
    BOX   = 3'd4,
    RSVD  = 3'd5
  } tp_mode_e;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  // Colour-bar palette, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Pixel-counter / colour bus between the HDMI transceiver and the pattern source.
interface test_pattern_gen_if #(parameter int CW = 26);
  logic [CW-1:0] cntX;
  logic [CW-1:0] cntY;
  logic [2:0]    mode;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic [7:0]    frame_cnt;

  // Transceiver side: owns the counters and mode select.
  modport master (output cntX, cntY, mode, input red, green, blue, frame_cnt);
  // Pattern source side.
  modport slave  (input cntX, cntY, mode, output red, green, blue, frame_cnt);
endinterface

// File: rtl/bounce_box_ctrl.sv
// One axis of the bouncing box: steps by STEP per enabled cycle, clamps and
// reverses at 0 and LIMIT-SIZE.
module bounce_box_ctrl #(
  parameter int CW    = 26,
  parameter int LIMIT = 800,
  parameter int SIZE  = 64,
  parameter int STEP  = 2
) (
  input  logic          pixclk,
  input  logic          rst_n,
  input  logic          step_en,
  output logic [CW-1:0] pos
);

  localparam logic [CW-1:0] L_CW   = CW'(LIMIT);
  localparam logic [CW-1:0] S_CW   = CW'(SIZE);
  localparam logic [CW-1:0] P_CW   = CW'(STEP);
  localparam logic [CW-1:0] MAX_CW = CW'(LIMIT - SIZE);

  logic [CW-1:0] r_pos, w_pos;
  logic          r_left, w_left;

  // Next position: move one step, or clamp to the edge and flip direction.
  always_comb begin
    w_pos  = r_pos;
    w_left = r_left;
    if (!r_left) begin
      if (r_pos + P_CW + S_CW <= L_CW) w_pos = r_pos + P_CW;
      else begin
        w_pos  = MAX_CW;
        w_left = 1'b1;
      end
    end else begin
      if (r_pos >= P_CW) w_pos = r_pos - P_CW;
      else begin
        w_pos  = '0;
        w_left = 1'b0;
      end
    end
  end

  // Position/direction register, updated once per frame.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_left <= 1'b0;
    end else if (step_en) begin
      r_pos  <= w_pos;
      r_left <= w_left;
    end
  end

  assign pos = r_pos;

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode video test-pattern source, one-cycle registered RGB output.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int H_PIXEL  = 800,
  parameter int V_PIXEL  = 600,
  parameter int CW       = 26,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic             pixclk,
  input  logic             rst_n,
  test_pattern_gen_if.slave bus
);

  localparam logic [CW-1:0] H_CW   = CW'(H_PIXEL);
  localparam logic [CW-1:0] V_CW   = CW'(V_PIXEL);
  localparam logic [CW-1:0] HX_CW  = CW'(H_PIXEL / 2);
  localparam logic [CW-1:0] HY_CW  = CW'(V_PIXEL / 2);
  localparam logic [CW-1:0] BOX_CW = CW'(BOX_SIZE);
  localparam int            BAR_W  = H_PIXEL / 8;
  localparam int            AW     = $clog2(H_PIXEL) + 1;
  localparam logic [AW-1:0] ACC_INC = AW'(256);
  localparam logic [AW-1:0] ACC_H   = AW'(H_PIXEL);

  logic          w_fs, w_active;
  logic [2:0]    r_mode_q, w_mode;
  logic [7:0]    r_fc;
  logic [23:0]   r_rgb, w_rgb;
  logic [CW-1:0] w_bx, w_by;
  logic [AW-1:0] r_acc, w_acc, w_sum;
  logic [7:0]    r_lvl, w_lvl;
  logic [2:0]    w_bar;

  assign w_fs     = (bus.cntX == '0) && (bus.cntY == '0);
  assign w_active = (bus.cntX < H_CW) && (bus.cntY < V_CW);
  // The mode latched at frame start already governs pixel (0,0).
  assign w_mode   = w_fs ? bus.mode : r_mode_q;

  bounce_box_ctrl #(.CW(CW), .LIMIT(H_PIXEL), .SIZE(BOX_SIZE), .STEP(BOX_STEP))
    u_box_x (.pixclk(pixclk), .rst_n(rst_n), .step_en(w_fs), .pos(w_bx));
  bounce_box_ctrl #(.CW(CW), .LIMIT(V_PIXEL), .SIZE(BOX_SIZE), .STEP(BOX_STEP))
    u_box_y (.pixclk(pixclk), .rst_n(rst_n), .step_en(w_fs), .pos(w_by));

  // Ramp DDA: tracks floor(cntX*256/H_PIXEL) assuming cntX advances by one per clock.
  always_comb begin
    w_sum = r_acc + ACC_INC;
    w_acc = w_sum;
    w_lvl = r_lvl;
    if (bus.cntX == '0) begin
      w_acc = '0;
      w_lvl = '0;
    end else if (w_sum >= ACC_H) begin
      w_acc = w_sum - ACC_H;
      w_lvl = (r_lvl == 8'hFF) ? 8'hFF : r_lvl + 8'd1;
    end
  end

  // Bar index by threshold compare; the last bar absorbs the width remainder.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (bus.cntX >= CW'(i * BAR_W)) w_bar = 3'(i);
  end

  // Pixel colour for the effective mode.
  always_comb begin
    w_rgb = BLACK;
    case (w_mode)
      QUAD: begin
        if (bus.cntY < HY_CW) w_rgb = (bus.cntX < HX_CW) ? RED  : GREEN;
        else                  w_rgb = (bus.cntX < HX_CW) ? BLUE : WHITE;
      end
      BARS:  w_rgb = bar_color(w_bar);
      CHECK: w_rgb = (bus.cntX[5] ^ bus.cntY[5]) ? WHITE : BLACK;
      RAMP:  w_rgb = {w_lvl, w_lvl, w_lvl};
      BOX: begin
        if (bus.cntX >= w_bx && bus.cntX < w_bx + BOX_CW &&
            bus.cntY >= w_by && bus.cntY < w_by + BOX_CW) w_rgb = WHITE;
        else                                              w_rgb = BLUE;
      end
      default: w_rgb = BLACK;
    endcase
  end

  // Registered state: mode, frame counter, DDA, and the blanked RGB output.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 3'(QUAD);
      r_fc     <= '0;
      r_acc    <= '0;
      r_lvl    <= '0;
      r_rgb    <= '0;
    end else begin
      if (w_fs) begin
        r_mode_q <= bus.mode;
        r_fc     <= r_fc + 8'd1;
      end
      r_acc <= w_acc;
      r_lvl <= w_lvl;
      r_rgb <= w_active ? w_rgb : BLACK;
    end
  end

  assign bus.red       = r_rgb[23:16];
  assign bus.green     = r_rgb[15:8];
  assign bus.blue      = r_rgb[7:0];
  assign bus.frame_cnt = r_fc;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: expected pixels are queued on drive
// and compared when the registered output appears one clock later.
module tb_test_pattern_gen;

  localparam int CW = 26;
  localparam int H  = 800;
  localparam int V  = 600;
  localparam int BS = 64;
  localparam int ST = 2;

  typedef struct {
    bit          en;
    string       tag;
    logic [23:0] rgb;
  } exp_t;

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;
  test_pattern_gen_if #(.CW(CW)) bus();

  test_pattern_gen #(.H_PIXEL(H), .V_PIXEL(V), .CW(CW), .BOX_SIZE(BS), .BOX_STEP(ST))
    dut (.pixclk(pixclk), .rst_n(rst_n), .bus(bus));

  always #5 pixclk = ~pixclk;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t q[$];

  // Reference state of the pattern source.
  int m_mode = 0, m_fc = 0, m_bx = 0, m_by = 0;
  bit m_lx = 0, m_ly = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] px(input int x, input int y, input int md,
                                     input int bx, input int by);
    logic [23:0] bars [8];
    int b, v;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (x >= H || y >= V) return 24'h0;
    case (md)
      0: begin
        if (y < V/2) return (x < H/2) ? 24'hFF0000 : 24'h00FF00;
        else         return (x < H/2) ? 24'h0000FF : 24'hFFFFFF;
      end
      1: begin
        b = x / (H/8);
        if (b > 7) b = 7;
        return bars[b];
      end
      2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      3: begin
        v = (x * 256) / H;
        if (v > 255) v = 255;
        return {8'(v), 8'(v), 8'(v)};
      end
      4: return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'h0;
    endcase
  endfunction

  task automatic mv(input int p, input bit l, input int lim, output int np, output bit nl);
    np = p;
    nl = l;
    if (!l) begin
      if (p + ST + BS <= lim) np = p + ST;
      else begin np = lim - BS; nl = 1'b1; end
    end else begin
      if (p >= ST) np = p - ST;
      else begin np = 0; nl = 1'b0; end
    end
  endtask

  // Drive one pixel for one clock; check the registered result if en.
  task automatic tick(input int x, input int y, input int m, input bit en, input string tag);
    exp_t e;
    int   md;
    bus.cntX = CW'(x);
    bus.cntY = CW'(y);
    bus.mode = 3'(m);
    md = (x == 0 && y == 0) ? m : m_mode;
    e.en  = en;
    e.tag = tag;
    e.rgb = px(x, y, md, m_bx, m_by);
    q.push_back(e);
    @(posedge pixclk);
    #1;
    if (x == 0 && y == 0) begin
      m_mode = m;
      m_fc   = (m_fc + 1) & 255;
      mv(m_bx, m_lx, H, m_bx, m_lx);
      mv(m_by, m_ly, V, m_by, m_ly);
    end
    e = q.pop_front();
    if (e.en) chk(e.tag, {8'h0, bus.red, bus.green, bus.blue}, {8'h0, e.rgb});
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear at once.
  task automatic do_rst(input bit en);
    rst_n = 1'b0;
    #1;
    if (en) begin
      chk("rst_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
      chk("rst_fc", {24'h0, bus.frame_cnt}, 32'h0);
    end
    #2;
    rst_n = 1'b1;
    m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_lx = 0; m_ly = 0;
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen736;
    int n;
    bus.cntX = CW'(H);
    bus.cntY = CW'(V);
    bus.mode = 3'd0;
    repeat (3) @(posedge pixclk);
    #1;
    chk("reset_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
    chk("reset_fc", {24'h0, bus.frame_cnt}, 32'h0);
    rst_n = 1'b1;

    // QUAD corners and blanking
    tick(0,   0,   0, 1, "quad_00");
    chk("fc_one", {24'h0, bus.frame_cnt}, 32'(m_fc));
    tick(400, 0,   0, 1, "quad_tr");
    tick(399, 300, 0, 1, "quad_bl");
    tick(400, 300, 0, 1, "quad_br");
    tick(800, 0,   0, 1, "quad_blank");

    // mid-frame mode change waits for the next frame start
    tick(100, 50,  2, 1, "mid_hold");
    tick(32,  0,   2, 1, "mid_hold2");
    tick(500, 400, 2, 1, "mid_hold3");
    tick(0,   0,   2, 1, "check_00");
    tick(32,  0,   2, 1, "check_32");
    tick(32,  32,  2, 1, "check_3232");

    // BARS
    tick(0,   0,   1, 1, "bars_00");
    tick(99,  5,   1, 1, "bars_99");
    tick(100, 5,   1, 1, "bars_100");
    tick(700, 5,   1, 1, "bars_700");
    tick(799, 5,   1, 1, "bars_799");
    tick(800, 5,   1, 1, "bars_blank");

    // RAMP: full sequential line sweep
    tick(0, 0, 3, 1, "ramp_fs");
    for (int x = 0; x < H + 4; x++) tick(x, 1, 3, 1, $sformatf("ramp_x%0d", x));

    // mid-line reset, then QUAD immediately
    tick(0, 0, 1, 0, "");
    tick(0, 7, 1, 1, "pre_rst");
    do_rst(1'b1);
    tick(400, 300, 5, 1, "post_rst_quad");
    tick(10,  10,  5, 1, "post_rst_quad2");

    // BOX: three frame starts put the box at (6,6)
    for (int f = 0; f < 3; f++) begin
      tick(0, 0, 4, 0, "");
      tick(300, 300, 4, 0, "");
    end
    tick(6,  6,  4, 1, "box_66");
    tick(5,  6,  4, 1, "box_56");
    tick(69, 69, 4, 1, "box_6969");
    tick(70, 69, 4, 1, "box_7069");

    // run the box into the right edge and back
    seen736 = 1'b0;
    n = 0;
    while (n < 500) begin
      tick(0, 0, 4, 0, "");
      tick(m_bx, m_by, 4, 1, "box_in");
      if (m_bx > 0) tick(m_bx - 1, m_by, 4, 1, "box_left");
      if (m_bx == H - BS) seen736 = 1'b1;
      else if (seen736 && m_bx == H - BS - ST) break;
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      n_bad++;
      $display("FAIL box_bound got=%0d exp=<500", n);
    end
    tick(797, m_by, 4, 1, "box_rev_in");
    tick(798, m_by, 4, 1, "box_rev_out");

    // frame counter wrap
    do_rst(1'b0);
    for (int f = 0; f < 256; f++) begin
      tick(0, 0, 0, 0, "");
      if (f == 254) chk("fc_255", {24'h0, bus.frame_cnt}, 32'(m_fc));
      tick(10, 10, 0, 0, "");
    end
    chk("fc_wrap", {24'h0, bus.frame_cnt}, 32'h0);
    tick(10, 10, 0, 1, "wrap_quad");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
# test_pattern_gen

Parametrised, multi-mode video test-pattern source that drives `red`/`green`/`blue` into the HDMI transceiver from its `cntX`/`cntY` pixel counters. It replaces the fixed four-quadrant generator with selectable patterns, frame-synchronous mode switching, and a moving-box motion test. Outputs are registered, with a fixed one-cycle latency.

## Interface
- `H_PIXEL`, 800: active pixels per line; must be ≥ 256
- `V_PIXEL`, 600: active lines per frame
- `CW`, 26: width of the `cntX`/`cntY` counters
- `BOX_SIZE`, 64: moving-box edge length in pixels
- `BOX_STEP`, 2: box displacement per frame, per axis
- `pixclk` in 1: pixel clock; the single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `cntX` in CW: current pixel column from the transceiver; advances by 1 per `pixclk` within a line
- `cntY` in CW: current line from the transceiver
- `mode` in 3: requested pattern; sampled only at frame start
- `red`, `green`, `blue` out 8 each: pixel colour
- `frame_cnt` out 8: frames since reset, wrapping 255 → 0

## Operation
- Active area is `cntX < H_PIXEL && cntY < V_PIXEL`. Outside it, RGB = 0.
- Frame start is `cntX == 0 && cntY == 0`. On that cycle:
  - `mode` is latched into `mode_q`.
  - `frame_cnt` increments.
  - Box position steps.
  - Mode changes at any other time have no visible effect until the next frame start.
- `mode_q` encodings:
  - 0 QUAD: quadrants split at `hx = H_PIXEL/2` and `hy = V_PIXEL/2`, with `x ≥ hx` counting as right and `y ≥ hy` as bottom. Top-left red (255,0,0), top-right green, bottom-left blue, bottom-right white.
  - 1 BARS: 8 vertical bars, each `H_PIXEL/8` wide; the integer remainder goes to the last bar. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - 2 CHECK: white if `cntX[5] ^ cntY[5]`, else black.
  - 3 RAMP: R = G = B = `floor(cntX*256/H_PIXEL)`.
    - Computed by a DDA accumulator, not a divider.
    - At `cntX == 0`: accumulator = 0, level = 0.
    - Each subsequent pixel: accumulator += 256. If the result ≥ `H_PIXEL`, subtract `H_PIXEL` and increment the level. At most one subtraction per cycle, guaranteed by `H_PIXEL ≥ 256`.
  - 4 BOX: white square `[bx, bx+BOX_SIZE) × [by, by+BOX_SIZE)` on a blue background.
  - 5–7: solid black (reserved).
- Box motion is independent per axis; X is described, Y is identical using `V_PIXEL`:
  - Moving right: if `bx + BOX_STEP + BOX_SIZE ≤ H_PIXEL`, add `BOX_STEP`. Otherwise set `bx = H_PIXEL - BOX_SIZE` and reverse direction.
  - Moving left: if `bx ≥ BOX_STEP`, subtract `BOX_STEP`. Otherwise set `bx = 0` and reverse direction.
  - The box moves in every mode, not only in BOX.
- Width rules:
  - All comparisons use CW bits.
  - The accumulator uses `$clog2(H_PIXEL)+1` bits.
  - The level is 8 bits and saturates at 255.

## Timing
- Latency is 1 cycle: RGB at cycle t+1 reflects `cntX`/`cntY`/`mode_q` at cycle t.
- The mode latched at frame start applies starting with the pixel (0,0) itself.
- Reset values:
  - RGB = 0, `frame_cnt` = 0.
  - `mode_q` = 0 (QUAD), box = (0,0), both directions positive.
  - Accumulator = 0, level = 0.
- Reset asserted mid-frame clears all outputs asynchronously. After release, the block generates QUAD immediately with no wait for frame start.
- A frame start occurring together with a box edge hit applies the clamp and the direction flip in the same cycle.
- `frame_cnt` wraps 255 → 0 without a flag.

## Structure
- Package `test_pattern_pkg` holds:
  - mode enum `tp_mode_e`: QUAD, BARS, CHECK, RAMP, BOX, RSVD.
  - 24-bit colour constants: WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK.
- Sub-module `bounce_box_ctrl`:
  - Parameters: `LIMIT`, `SIZE`, `STEP`.
  - Ports: `pixclk`, `rst_n`, `step_en`, `pos` out.
  - Instantiated twice, once for X and once for Y.

## Test plan
- QUAD, defaults:
  - (0,0) → 255,0,0
  - (400,0) → 0,255,0
  - (399,300) → 0,0,255
  - (400,300) → 255,255,255
  - (800,0) → 0,0,0
  - All checked one cycle later.
- `mode` set to 2 at (100,50) mid-frame → QUAD output persists to end of frame. From the next (0,0): (0,0) → black, (32,0) → white.
- BARS: x=99 → white; x=100 → yellow (255,255,0); x=799 → black.
- RAMP:
  - x=0 → 0
  - x=400 → 128
  - x=799 → 255
  - x=3 → 0
  - x=4 → 1
  - Sweep every x in a line and compare against the reference formula.
- BOX: after 3 frame starts, box = (6,6), so (6,6) → white and (5,6) → blue. Run until `bx` reaches 736 → direction reverses, and the next frame gives `bx` = 734.
- Assert `rst_n` low mid-line → RGB and `frame_cnt` read 0 within the same cycle. After release, 256 frame starts → `frame_cnt` = 0.
